// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment number update path.
package seg_pkg;

    localparam int         NUM_DIGITS         = 6;
    localparam int         BCD_MAX            = 999_999;
    localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        PUB,
        HOLD
    } seg_state_e;

    // A digit goes dark only while everything above it is zero and carries no decimal point.
    function automatic logic [4*NUM_DIGITS-1:0] blank_leading(
        input logic [4*NUM_DIGITS-1:0] bcd,
        input logic [NUM_DIGITS-1:0]   dp,
        input logic [3:0]              code
    );
        logic [4*NUM_DIGITS-1:0] res;
        logic                    lead;
        res  = bcd;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead = lead && (bcd[4*i +: 4] == 4'd0) && !dp[i];
            if (lead) begin
                res[4*i +: 4] = code;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, BIN_W steps per conversion.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [23:0]      bcd
);

    localparam int SRW = 24 + BIN_W;
    localparam int CW  = $clog2(BIN_W);

    logic [SRW-1:0] sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           run_q, run_d;

    function automatic logic [SRW-1:0] dabble_step(input logic [SRW-1:0] s);
        logic [SRW-1:0] t;
        t = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SRW-2:0], 1'b0};
    endfunction

    // done marks the edge that performs the final step, so bcd is valid the cycle after.
    assign done = run_q && (cnt_q == CW'(BIN_W - 1));
    assign bcd  = sr_q[SRW-1 -: 24];

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            sr_d  = {24'd0, bin};
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            sr_d  = dabble_step(sr_q);
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/seg_num_ctrl.sv
// Accepts a binary value, converts it to six BCD digits and publishes num/point/ovf atomically,
// then holds off further updates for UPD_CYCLES clocks.
module seg_num_ctrl
    import seg_pkg::*;
#(
    parameter int         BIN_W      = 20,
    parameter int         UPD_CYCLES = 5_000_000,
    parameter bit         LZ_BLANK   = 1'b1,
    parameter logic [3:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] data_in,
    input  logic [5:0]       dp_pos,
    input  logic             data_valid,
    output logic             in_ready,
    output logic [23:0]      num,
    output logic [5:0]       point,
    output logic             busy,
    output logic             ovf
);

    localparam logic [BIN_W-1:0] MAX_V     = BIN_W'(BCD_MAX);
    localparam int               HCW       = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(UPD_CYCLES - 1);

    seg_state_e       state_q, state_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic [23:0]      num_q, num_d;
    logic [5:0]       point_q, point_d;
    logic             ovf_q, ovf_d;
    logic             ovf_n_q, ovf_n_d;
    logic [5:0]       dp_q, dp_d;

    logic             accept;
    logic             too_big;
    logic [BIN_W-1:0] bin_clamped;
    logic             conv_done;
    logic [23:0]      conv_bcd;

    assign accept      = data_valid && in_ready_q;
    assign too_big     = data_in > MAX_V;
    assign bin_clamped = too_big ? MAX_V : data_in;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin   (bin_clamped),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        num_d      = num_q;
        point_d    = point_q;
        ovf_d      = ovf_q;
        ovf_n_d    = ovf_n_q;
        dp_d       = dp_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONV;
                    ovf_n_d = too_big;
                    dp_d    = dp_pos;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = PUB;
                end
            end
            PUB: begin
                num_d      = LZ_BLANK ? blank_leading(conv_bcd, dp_q, BLANK_CODE) : conv_bcd;
                point_d    = dp_q;
                ovf_d      = ovf_n_q;
                hold_cnt_d = '0;
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered from the next state so they line up with it.
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == CONV) || (state_d == PUB);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            num_q      <= '0;
            point_q    <= '0;
            ovf_q      <= 1'b0;
            ovf_n_q    <= 1'b0;
            dp_q       <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            num_q      <= num_d;
            point_q    <= point_d;
            ovf_q      <= ovf_d;
            ovf_n_q    <= ovf_n_d;
            dp_q       <= dp_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign num      = num_q;
    assign point    = point_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_seg_num_ctrl.sv
// Randomized and directed bench for seg_num_ctrl with a decimal-arithmetic reference model.
module tb_seg_num_ctrl;

    localparam int BIN_W      = 20;
    localparam int UPD_CYCLES = 8;
    localparam int PUB_LAT    = BIN_W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [BIN_W-1:0] data_in;
    logic [5:0]       dp_pos;
    logic             data_valid;
    logic             in_ready;
    logic [23:0]      num;
    logic [5:0]       point;
    logic             busy;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    seg_num_ctrl #(
        .BIN_W      (BIN_W),
        .UPD_CYCLES (UPD_CYCLES),
        .LZ_BLANK   (1'b1),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_pos     (dp_pos),
        .data_valid (data_valid),
        .in_ready   (in_ready),
        .num        (num),
        .point      (point),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: clamp, split into decimal digits, show every digit up to the larger of the
    // most significant nonzero digit and the highest decimal point; the rest are dark.
    function automatic logic [23:0] model_num(input int d, input logic [5:0] dp);
        int          v;
        int          t;
        int          msd;
        int          keep;
        int          p;
        int          digit;
        logic [23:0] res;
        v   = (d > 999_999) ? 999_999 : d;
        msd = 0;
        p   = 10;
        while (msd < 5 && v >= p) begin
            msd++;
            p = p * 10;
        end
        keep = msd;
        for (int i = 0; i < 6; i++) begin
            if (dp[i] && i > keep) keep = i;
        end
        res = '0;
        t   = v;
        for (int i = 0; i < 6; i++) begin
            digit = t % 10;
            t     = t / 10;
            res[4*i +: 4] = (i <= keep) ? digit[3:0] : 4'hF;
        end
        return res;
    endfunction

    // Present a value and return just after the accepting edge.
    task automatic send(input logic [BIN_W-1:0] d, input logic [5:0] dp);
        int waited;
        waited = 0;
        @(negedge clk);
        data_in    = d;
        dp_pos     = dp;
        data_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) $display("[TB] FAIL send_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
        else n_pass++;
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        dp_pos     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({num, point, busy, ovf, in_ready} !== 33'd0)
            $display("[TB] FAIL reset_outputs: num=%h point=%b busy=%b ovf=%b in_ready=%b required all 0",
                     num, point, busy, ovf, in_ready);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL ready_at_release: got %b required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || num !== 24'h0)
            $display("[TB] FAIL ready_after_release: in_ready=%b busy=%b num=%h required 1 0 000000",
                     in_ready, busy, num);
        else n_pass++;
    endtask

    task automatic test_latency;
        int bad_busy;
        int bad_num;
        bad_busy = 0;
        bad_num  = 0;
        send(20'd123456, 6'b000000);
        for (int k = 0; k < PUB_LAT; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (num !== 24'h000000) bad_num++;
            if (in_ready !== 1'b0) bad_busy++;
        end
        n_checks++;
        if (bad_busy != 0) $display("[TB] FAIL busy_during_conv: %0d bad samples required 0", bad_busy);
        else n_pass++;
        n_checks++;
        if (bad_num != 0) $display("[TB] FAIL num_early_change: %0d bad samples required 0", bad_num);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (num !== 24'h123456 || busy !== 1'b0)
            $display("[TB] FAIL latency_123456: num=%h busy=%b required 123456 0", num, busy);
        else n_pass++;
    endtask

    task automatic test_blanking;
        logic [19:0] vals [3];
        logic [5:0]  dps  [3];
        logic [23:0] exps [3];
        vals = '{20'd42, 20'd0, 20'd5};
        dps  = '{6'b000000, 6'b000000, 6'b000100};
        exps = '{24'hFFFF42, 24'hFFFFF0, 24'hFFF005};
        for (int i = 0; i < 3; i++) begin
            send(vals[i], dps[i]);
            repeat (PUB_LAT + 1) @(negedge clk);
            n_checks++;
            if (num !== exps[i] || point !== dps[i] || ovf !== 1'b0)
                $display("[TB] FAIL blank_%0d: num=%h point=%b ovf=%b required %h %b 0",
                         vals[i], num, point, ovf, exps[i], dps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow;
        send(20'd1_000_000, 6'b000000);
        repeat (PUB_LAT + 1) @(negedge clk);
        n_checks++;
        if (num !== 24'h999999 || ovf !== 1'b1)
            $display("[TB] FAIL ovf_clamp: num=%h ovf=%b required 999999 1", num, ovf);
        else n_pass++;
        send(20'd7, 6'b000000);
        repeat (PUB_LAT) @(negedge clk);
        n_checks++;
        if (ovf !== 1'b1 || num !== 24'h999999)
            $display("[TB] FAIL ovf_hold: num=%h ovf=%b required 999999 1", num, ovf);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (num !== 24'hFFFFF7 || ovf !== 1'b0)
            $display("[TB] FAIL ovf_clear: num=%h ovf=%b required FFFFF7 0", num, ovf);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int          acc_cyc [4];
        int          n_acc;
        int          guard;
        logic [19:0] last_val;
        n_acc    = 0;
        guard    = 0;
        last_val = 20'd31;
        @(negedge clk);
        data_in    = last_val;
        dp_pos     = 6'b000000;
        data_valid = 1'b1;
        while (n_acc < 4 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc < 4) begin
                    last_val = 20'($urandom_range(0, 999_999));
                    data_in  = last_val;
                end else begin
                    data_valid = 1'b0;
                end
            end
        end
        data_valid = 1'b0;
        n_checks++;
        if (n_acc != 4) $display("[TB] FAIL b2b_accepts: got %0d required 4", n_acc);
        else n_pass++;
        for (int i = 1; i < n_acc; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != PUB_LAT + 1 + UPD_CYCLES)
                $display("[TB] FAIL b2b_spacing_%0d: got %0d required %0d", i,
                         acc_cyc[i] - acc_cyc[i-1], PUB_LAT + 1 + UPD_CYCLES);
            else n_pass++;
        end
        repeat (PUB_LAT + 1) @(negedge clk);
        n_checks++;
        if (num !== model_num(int'(last_val), 6'b000000))
            $display("[TB] FAIL b2b_last_value: num=%h required %h", num,
                     model_num(int'(last_val), 6'b000000));
        else n_pass++;
    endtask

    task automatic test_random;
        logic [19:0] v;
        logic [5:0]  dp;
        logic [23:0] exp_num;
        logic        exp_ovf;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 20'($urandom_range(0, 99));
                1:       v = 20'($urandom_range(0, 9_999));
                2:       v = 20'($urandom_range(0, 999_999));
                default: v = 20'($urandom_range(990_000, 1_048_575));
            endcase
            dp      = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) dp = 6'd0;
            exp_num = model_num(int'(v), dp);
            exp_ovf = (int'(v) > 999_999);
            send(v, dp);
            repeat (PUB_LAT + 1) @(negedge clk);
            n_checks++;
            if (num !== exp_num || point !== dp || ovf !== exp_ovf)
                $display("[TB] FAIL random_%0d (in=%0d dp=%b): num=%h point=%b ovf=%b required %h %b %b",
                         i, v, dp, num, point, ovf, exp_num, dp, exp_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_conv;
        send(20'd654321, 6'b000010);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({num, point, busy, ovf, in_ready} !== 33'd0)
            $display("[TB] FAIL reset_mid_conv: num=%h point=%b busy=%b ovf=%b in_ready=%b required all 0",
                     num, point, busy, ovf, in_ready);
        else n_pass++;
        rst_n = 1'b1;
        repeat (PUB_LAT + 2) @(negedge clk);
        n_checks++;
        if (num !== 24'h0 || busy !== 1'b0)
            $display("[TB] FAIL conv_abandoned: num=%h busy=%b required 000000 0", num, busy);
        else n_pass++;
        send(20'd999_999, 6'b000000);
        repeat (PUB_LAT + 1) @(negedge clk);
        n_checks++;
        if (num !== 24'h999999 || ovf !== 1'b0)
            $display("[TB] FAIL after_reset_999999: num=%h ovf=%b required 999999 0", num, ovf);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_blanking;
        test_overflow;
        test_back_to_back;
        test_random;
        test_reset_mid_conv;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
